bcd_score_counter: RTL and testbench



---
 rtl/score_pkg.sv | 19 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_score_counter.sv | 90 +++++++++
 tb/tb_bcd_score_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared BCD constants, FSM encodings and elaboration helpers for the score counter
package score_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic {ST_PLAY = 1'b0, ST_WON = 1'b1} state_t;
    function automatic logic [31:0] int_to_bcd(input int value, input int ndigits);
        logic [31:0] r;
        int v;
        r = '0;
        v = value;
        for (int k = 0; k < 8; k++) begin
            if (k < ndigits) begin
                r[BCD_W*k +: BCD_W] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit with clear, clamped load and carry/borrow-chained up/down step
module bcd_digit
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             cin,
    input  logic             bin,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    output logic [BCD_W-1:0] q,
    output logic [BCD_W-1:0] ld_q,
    output logic             cout,
    output logic             bout,
    output logic             is9,
    output logic             is0
);
    logic [BCD_W-1:0] q_nxt;
    assign ld_q = (load_nib > BCD_MAX) ? BCD_MAX : load_nib;
    assign is9  = q == BCD_MAX;
    assign is0  = q == '0;
    assign cout = cin & is9;
    assign bout = bin & is0;
    always_comb
        q_nxt = clr ? '0 :
                load ? ld_q :
                (inc && cin) ? (is9 ? '0 : q + 4'd1) :
                (dec && bin) ? (is0 ? BCD_MAX : q - 4'd1) : q;
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else q <= q_nxt;
endmodule

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: N-digit BCD up/down score counter with load, wrap/saturate and win FSM
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int WRAP_MODE  = 1,
    parameter int WIN_SCORE  = 11
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        d_inc,
    input  logic                        d_dec,
    input  logic                        d_clr,
    input  logic                        d_load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic                        at_zero,
    output logic                        at_max,
    output logic                        won,
    output logic                        win_pulse,
    output logic                        ovf_pulse
);
    localparam int W = BCD_W * NUM_DIGITS;
    localparam int MAX_VAL = 10 ** NUM_DIGITS - 1;
    localparam logic [31:0] WIN_FULL = int_to_bcd(WIN_SCORE, NUM_DIGITS);
    localparam logic [31:0] PRE_FULL = int_to_bcd((WIN_SCORE == 0) ? 0 : WIN_SCORE - 1, NUM_DIGITS);
    localparam logic [W-1:0] WIN_BCD = WIN_FULL[W-1:0];
    localparam logic [W-1:0] PRE_BCD = PRE_FULL[W-1:0];
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("bcd_score_counter: NUM_DIGITS must be 1..8");
    end
    if (WIN_SCORE < 0 || WIN_SCORE > MAX_VAL) begin : g_bad_win
        $error("bcd_score_counter: WIN_SCORE exceeds counter range");
    end
    logic [NUM_DIGITS:0] carry, borrow;
    logic [NUM_DIGITS-1:0] is9, is0;
    logic [W-1:0] ld_clamped;
    logic step_inc, step_dec, inc_en, dec_en, ovf_ev, hit_win, ld_win, win_ev;
    state_t state, state_nxt;
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc_en),
            .dec      (dec_en),
            .cin      (carry[k]),
            .bin      (borrow[k]),
            .clr      (d_clr),
            .load     (d_load),
            .load_nib (load_val[BCD_W*k +: BCD_W]),
            .q        (digits[BCD_W*k +: BCD_W]),
            .ld_q     (ld_clamped[BCD_W*k +: BCD_W]),
            .cout     (carry[k+1]),
            .bout     (borrow[k+1]),
            .is9      (is9[k]),
            .is0      (is0[k])
        );
    end
    assign at_max   = &is9;
    assign at_zero  = &is0;
    assign step_inc = (state == ST_PLAY) & ~d_clr & ~d_load & d_inc & ~d_dec;
    assign step_dec = (state == ST_PLAY) & ~d_clr & ~d_load & d_dec & ~d_inc;
    assign inc_en   = step_inc & ((WRAP_MODE != 0) | ~at_max);
    assign dec_en   = step_dec & ((WRAP_MODE != 0) | ~at_zero);
    // A carry or borrow out of the top digit is exactly a wrap/saturate event
    assign ovf_ev   = (step_inc & carry[NUM_DIGITS]) | (step_dec & borrow[NUM_DIGITS]);
    assign hit_win  = (WIN_SCORE != 0) && step_inc && (digits == PRE_BCD);
    assign ld_win   = (WIN_SCORE != 0) && (ld_clamped >= WIN_BCD);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_PLAY;
        else state <= state_nxt;
    always_comb
        state_nxt = d_clr ? ST_PLAY :
                    d_load ? (ld_win ? ST_WON : ST_PLAY) :
                    hit_win ? ST_WON : state;
    always_comb begin
        won    = state == ST_WON;
        win_ev = (state == ST_PLAY) && (state_nxt == ST_WON);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            win_pulse <= 1'b0;
            ovf_pulse <= 1'b0;
        end else begin
            win_pulse <= win_ev;
            ovf_pulse <= ovf_ev;
        end
endmodule

// File: tb/tb_bcd_score_counter.sv
// tb_bcd_score_counter: three parameter variants driven in lockstep, checked by a scoreboard against an integer model
module tb_bcd_score_counter;
    typedef struct packed {
        logic [7:0] d;
        logic az, am, won, wp, op;
    } obs_t;
    typedef obs_t [2:0] trio_t;
    logic clk = 1'b0;
    logic reset;
    logic d_inc, d_dec, d_clr, d_load;
    logic [7:0] load_val;
    logic [2:0][7:0] dg;
    logic [2:0] az, am, wn, wp, op;
    trio_t act, ent;
    trio_t sb[$];
    int compared = 0;
    int mismatched = 0;
    int wraps[3] = '{1, 1, 0};
    int wins[3] = '{11, 0, 0};
    int sc[3];
    bit mw[3], mwp[3], mop[3];
    always #5 clk = ~clk;
    for (genvar k = 0; k < 3; k++) begin : g_dut
        bcd_score_counter #(.NUM_DIGITS(2), .WRAP_MODE((k == 2) ? 0 : 1), .WIN_SCORE((k == 0) ? 11 : 0)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .d_inc     (d_inc),
            .d_dec     (d_dec),
            .d_clr     (d_clr),
            .d_load    (d_load),
            .load_val  (load_val),
            .digits    (dg[k]),
            .at_zero   (az[k]),
            .at_max    (am[k]),
            .won       (wn[k]),
            .win_pulse (wp[k]),
            .ovf_pulse (op[k])
        );
        assign act[k] = {dg[k], az[k], am[k], wn[k], wp[k], op[k]};
    end
    function automatic int bcd_val(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction
    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            sc[i] = 0; mw[i] = 0; mwp[i] = 0; mop[i] = 0;
        end
    endtask
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            mwp[i] = 0;
            mop[i] = 0;
            if (d_clr) begin
                sc[i] = 0;
                mw[i] = 0;
            end else if (d_load) begin
                sc[i] = bcd_val(load_val);
                mwp[i] = (wins[i] != 0) && (sc[i] >= wins[i]) && !mw[i];
                mw[i] = (wins[i] != 0) && (sc[i] >= wins[i]);
            end else if (!mw[i] && d_inc && !d_dec) begin
                if (sc[i] == 99) begin
                    mop[i] = 1;
                    sc[i] = (wraps[i] != 0) ? 0 : 99;
                end else sc[i]++;
                if (wins[i] != 0 && sc[i] == wins[i]) begin
                    mw[i] = 1;
                    mwp[i] = 1;
                end
            end else if (!mw[i] && d_dec && !d_inc) begin
                if (sc[i] == 0) begin
                    mop[i] = 1;
                    sc[i] = (wraps[i] != 0) ? 99 : 0;
                end else sc[i]--;
            end
        end
    endtask
    task automatic push_expect();
        trio_t t;
        for (int i = 0; i < 3; i++)
            t[i] = {to_bcd(sc[i]), sc[i] == 0, sc[i] == 99, mw[i], mwp[i], mop[i]};
        sb.push_back(t);
    endtask
    task automatic cyc(input bit i, input bit dd, input bit c, input bit l, input logic [7:0] lv);
        d_inc = i; d_dec = dd; d_clr = c; d_load = l; load_val = lv;
        @(posedge clk);
        #1;
        model_edge();
        push_expect();
        @(negedge clk);
        #1;
    endtask
    // Reset lands between edges; the entry must already hold at the following negedge
    task automatic areset();
        d_inc = 0; d_dec = 0; d_clr = 0; d_load = 0;
        @(posedge clk);
        #2;
        reset = 1;
        sb.delete();
        model_reset();
        push_expect();
        @(negedge clk);
        #1;
        reset = 0;
    endtask
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            ent = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (act[i] !== ent[i]) begin
                    mismatched++;
                    $display("FAIL dut%0d t=%0t got d=%h az=%b am=%b won=%b wp=%b op=%b want d=%h az=%b am=%b won=%b wp=%b op=%b",
                             i, $time, act[i].d, act[i].az, act[i].am, act[i].won, act[i].wp, act[i].op,
                             ent[i].d, ent[i].az, ent[i].am, ent[i].won, ent[i].wp, ent[i].op);
                end
            end
        end
    end
    initial begin
        reset = 1; d_inc = 0; d_dec = 0; d_clr = 0; d_load = 0; load_val = '0;
        model_reset();
        push_expect();
        @(negedge clk);
        #1;
        reset = 0;
        for (int n = 0; n < 12; n++) cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h99);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h99);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h20);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'hFA);
        cyc(1, 0, 1, 1, 8'h55);
        cyc(0, 0, 0, 1, 8'h05);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h10);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h15);
        cyc(0, 0, 1, 0, 8'h00);
        for (int n = 0; n < 7; n++) cyc(1, 0, 0, 0, 8'h00);
        areset();
        cyc(1, 0, 0, 0, 8'h00);
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) areset();
            else cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
                     $urandom_range(0, 9) == 0, 8'($urandom));
        end
        @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
